// File: rtl/bit_serializer.sv
// bit_serializer: parallel word to bit stream with a one-word holding buffer.
// Define SER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             a,
  output logic             a_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] hold_d;
  logic             hold_full_q;
  logic             hold_full_d;
  logic             a_q;
  logic             a_d;
  logic             a_valid_q;
  logic             a_valid_d;
  logic             fs_q;
  logic             fs_d;
`ifdef SER_PARITY_EN
  logic             par_q;
  logic             par_d;
`endif

  logic             accept;
  logic             fin;
  logic             load;
  logic [WIDTH-1:0] load_word;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] tail(
    input logic [WIDTH-1:0] w
  );
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign in_ready = ~rst & ~hold_full_q;
  assign accept   = in_valid & in_ready;

  // fin marks a cycle whose next edge may start a new word
  always_comb begin
    fin = 1'b1;
    unique case (state_q)
      IDLE: fin = 1'b1;
`ifdef SER_PARITY_EN
      SHIFT:  fin = 1'b0;
      PARITY: fin = 1'b1;
`else
      SHIFT:  fin = (cnt_q == LAST);
`endif
      default: fin = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    a_d         = a_q;
    a_valid_d   = a_valid_q;
    fs_d        = 1'b0;
`ifdef SER_PARITY_EN
    par_d       = par_q;
`endif
    load        = 1'b0;
    load_word   = in_data;

    if (fin) begin
      if (hold_full_q) begin
        load        = 1'b1;
        load_word   = hold_q;
        hold_full_d = 1'b0;
      end else if (accept) begin
        load        = 1'b1;
        load_word   = in_data;
      end else begin
        state_d     = IDLE;
        a_d         = IDLE_BIT;
        a_valid_d   = 1'b0;
      end
    end else begin
      if (accept) begin
        hold_d      = in_data;
        hold_full_d = 1'b1;
      end
`ifdef SER_PARITY_EN
      if (cnt_q == LAST) begin
        state_d = PARITY;
        a_d     = par_q;
      end else begin
        a_d     = head(shreg_q);
        shreg_d = tail(shreg_q);
        cnt_d   = cnt_q + 1'b1;
      end
`else
      a_d     = head(shreg_q);
      shreg_d = tail(shreg_q);
      cnt_d   = cnt_q + 1'b1;
`endif
    end

    if (load) begin
      state_d   = SHIFT;
      a_d       = head(load_word);
      shreg_d   = tail(load_word);
      cnt_d     = '0;
      a_valid_d = 1'b1;
      fs_d      = 1'b1;
`ifdef SER_PARITY_EN
      par_d     = ^load_word;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      a_q         <= IDLE_BIT;
      a_valid_q   <= 1'b0;
      fs_q        <= 1'b0;
`ifdef SER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      a_q         <= a_d;
      a_valid_q   <= a_valid_d;
      fs_q        <= fs_d;
`ifdef SER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign a           = a_q;
  assign a_valid     = a_valid_q;
  assign frame_start = fs_q;
  assign busy        = (state_q != IDLE) | hold_full_q;

endmodule
